// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, response and memory-port signals for mem_port_arbiter.
//   slave  : arbiter view (takes requests, drives responses and the memory port)
//   master : environment view (requesters plus memory model)
// Ports: req{0,1}_{valid,addr,wdata,we} / req{0,1}_ready, rsp{0,1}_valid,
//        rsp_rdata, rsp_err, sel, mem_{valid,addr,wdata,we} / mem_ready,
//        mem_rsp_{valid,rdata}.
interface mem_port_arbiter_if;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_addr,  req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_we,    req1_we;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        sel;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport slave (
    input  req0_valid, req1_valid, req0_addr, req1_addr,
           req0_wdata, req1_wdata, req0_we, req1_we,
           mem_ready, mem_rsp_valid, mem_rsp_rdata,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_rdata, rsp_err, sel,
           mem_valid, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0_valid, req1_valid, req0_addr, req1_addr,
           req0_wdata, req1_wdata, req0_we, req1_we,
           mem_ready, mem_rsp_valid, mem_rsp_rdata,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_rdata, rsp_err, sel,
           mem_valid, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter sharing one 32-bit memory port.
// One transaction in flight: IDLE picks a winner and latches its fields,
// ISSUE holds mem_valid until mem_ready, WAIT waits for the single response
// (or times out after TIMEOUT_CYCLES) and pulses rsp{sel}_valid.
// Ports: clk, reset (sync, active high), bus (mem_port_arbiter_if.slave).
// reqN_ready is combinational; every other output is registered.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  state_t      state, state_nxt;
  req_t [1:0]  req;
  logic [1:0]  req_valid;
  logic        winner, accept, rsp_hit, tmo;
  logic        last_grant, sel;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        rsp0_valid, rsp1_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  wait_cnt;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req[0]    = '{addr: bus.req0_addr, wdata: bus.req0_wdata, we: bus.req0_we};
  assign req[1]    = '{addr: bus.req1_addr, wdata: bus.req1_wdata, we: bus.req1_we};

  // Tie goes to whoever was not served last.
  always_comb begin
    winner = 1'b0;
    case (req_valid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

  assign accept  = (state == IDLE) && (|req_valid);
  // A response in the timeout cycle takes priority over the error.
  assign rsp_hit = (state == WAIT) && bus.mem_rsp_valid;
  assign tmo     = (state == WAIT) && !bus.mem_rsp_valid && (wait_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)         state_nxt = ISSUE;
      ISSUE:   if (bus.mem_ready)  state_nxt = WAIT;
      WAIT:    if (rsp_hit || tmo) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel        <= 1'b0;
      last_grant <= 1'b1;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      mem_valid  <= (state_nxt == ISSUE);
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      if (accept) begin
        mem_addr  <= req[winner].addr;
        mem_wdata <= req[winner].wdata;
        mem_we    <= req[winner].we;
        sel       <= winner;
      end
      if (state == ISSUE && bus.mem_ready)
        wait_cnt <= '0;
      else if (state == WAIT && !bus.mem_rsp_valid)
        wait_cnt <= wait_cnt + 8'd1;
      if (rsp_hit || tmo) begin
        rsp0_valid <= ~sel;
        rsp1_valid <= sel;
        rsp_err    <= tmo;
        rsp_rdata  <= (rsp_hit && !mem_we) ? bus.mem_rsp_rdata : 32'd0;
        last_grant <= sel;
      end
    end
  end

  assign bus.req0_ready = accept && !winner;
  assign bus.req1_ready = accept &&  winner;
  assign bus.rsp0_valid = rsp0_valid;
  assign bus.rsp1_valid = rsp1_valid;
  assign bus.rsp_rdata  = rsp_rdata;
  assign bus.rsp_err    = rsp_err;
  assign bus.sel        = sel;
  assign bus.mem_valid  = mem_valid;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.mem_we     = mem_we;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT_CYCLES = 4).
// Inputs change 1 time unit after a rising edge; outputs are checked there
// (registered) or after a further settle delay (combinational ready).
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_addr = 0;  bus.req1_addr = 0;
    bus.req0_wdata = 0; bus.req1_wdata = 0;
    bus.req0_we = 0;    bus.req1_we = 0;
    bus.mem_ready = 0;  bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1;
    cyc(); cyc();
    total++; if ({bus.mem_valid, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.sel, bus.mem_we} !== 6'b0) begin bad++; $display("FAIL rst_ctrl got=%b exp=000000", {bus.mem_valid, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.sel, bus.mem_we}); end
    total++; if ({bus.mem_addr, bus.mem_wdata, bus.rsp_rdata} !== 96'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", {bus.mem_addr, bus.mem_wdata, bus.rsp_rdata}); end
    total++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", {bus.req0_ready, bus.req1_ready}); end
    reset = 0;
    cyc();
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_addr = 32'h0000_0100; bus.req1_addr = 32'h0000_0200;
    #1;
    total++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin bad++; $display("FAIL first_tie got=%b exp=10", {bus.req0_ready, bus.req1_ready}); end
    cyc();
    bus.req0_valid = 0; bus.req1_valid = 0;
    total++; if (bus.sel !== 1'b0 || bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h100) begin bad++; $display("FAIL first_accept sel=%b mv=%b addr=%h exp sel=0 mv=1 addr=100", bus.sel, bus.mem_valid, bus.mem_addr); end
    bus.mem_ready = 1;
    cyc();
    bus.mem_ready = 0; bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = 32'h1111_2222;
    cyc();
    bus.mem_rsp_valid = 0;
    total++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b10 || bus.rsp_rdata !== 32'h1111_2222) begin bad++; $display("FAIL first_rsp v=%b d=%h exp v=10 d=11112222", {bus.rsp0_valid, bus.rsp1_valid}, bus.rsp_rdata); end
  endtask

  task automatic test_round_robin;
    logic        g;
    logic [31:0] rd;
    idle_inputs();
    reset = 1; cyc(); reset = 0;
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_addr = 32'h0000_1000; bus.req1_addr = 32'h0000_2000;
    #1;
    for (int i = 0; i < 4; i++) begin
      g  = i[0];
      rd = g ? 32'hCAFE_F00D : 32'hDEAD_BEEF;
      total++; if ({bus.req1_ready, bus.req0_ready} !== (g ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_ready[%0d] got r1r0=%b exp grant=%0d", i, {bus.req1_ready, bus.req0_ready}, g); end
      cyc();
      total++; if (bus.sel !== g || bus.mem_valid !== 1'b1 || bus.mem_addr !== (g ? 32'h2000 : 32'h1000)) begin bad++; $display("FAIL rr_issue[%0d] sel=%b mv=%b addr=%h exp sel=%b", i, bus.sel, bus.mem_valid, bus.mem_addr, g); end
      total++; if ({bus.req0_ready, bus.req1_ready, bus.rsp_rdata} !== 34'd0) begin bad++; $display("FAIL rr_quiet[%0d] rdy=%b rdata=%h exp 0", i, {bus.req0_ready, bus.req1_ready}, bus.rsp_rdata); end
      bus.mem_ready = 1;
      cyc();
      bus.mem_ready = 0; bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = rd;
      total++; if (bus.mem_valid !== 1'b0) begin bad++; $display("FAIL rr_mv_drop[%0d] got=%b exp=0", i, bus.mem_valid); end
      cyc();
      bus.mem_rsp_valid = 0;
      total++; if ({bus.rsp1_valid, bus.rsp0_valid} !== (g ? 2'b10 : 2'b01) || bus.rsp_rdata !== rd || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rr_rsp[%0d] v1v0=%b d=%h e=%b exp grant=%0d d=%h", i, {bus.rsp1_valid, bus.rsp0_valid}, bus.rsp_rdata, bus.rsp_err, g, rd); end
      #1;
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    cyc();
  endtask

  task automatic test_backpressure;
    idle_inputs();
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_addr = 32'h0040_0010; bus.req0_wdata = 32'h1234_5678; bus.req0_we = 1;
    bus.req1_addr = 32'h0000_9000;
    #1;
    total++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin bad++; $display("FAIL bp_tie got=%b exp=10", {bus.req0_ready, bus.req1_ready}); end
    cyc();
    bus.req0_addr = 32'hFFFF_0000; bus.req0_wdata = 32'h0; bus.req0_we = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h0040_0010 || bus.mem_wdata !== 32'h1234_5678 || bus.mem_we !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d] mv=%b a=%h d=%h we=%b", i, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_we); end
      total++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, {bus.req0_ready, bus.req1_ready}); end
      cyc();
    end
    bus.mem_ready = 1;
    cyc();
    bus.mem_ready = 0; bus.req0_valid = 0; bus.req1_valid = 0;
    bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = 32'hFFFF_FFFF;
    cyc();
    bus.mem_rsp_valid = 0;
    total++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b10 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL bp_wr_rsp v=%b d=%h e=%b exp v=10 d=0 e=0", {bus.rsp0_valid, bus.rsp1_valid}, bus.rsp_rdata, bus.rsp_err); end
  endtask

  task automatic test_timeout;
    idle_inputs();
    bus.req1_valid = 1; bus.req1_addr = 32'h0000_3000;
    cyc();
    bus.req1_valid = 0; bus.mem_ready = 1;
    cyc();
    bus.mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      total++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin bad++; $display("FAIL tmo_early[W+%0d] got=%b exp=00", i, {bus.rsp0_valid, bus.rsp1_valid}); end
      cyc();
    end
    total++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b01 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'd0) begin bad++; $display("FAIL tmo_pulse v=%b e=%b d=%h exp v=01 e=1 d=0", {bus.rsp0_valid, bus.rsp1_valid}, bus.rsp_err, bus.rsp_rdata); end
    bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = 32'h7777_7777;
    cyc();
    bus.mem_rsp_valid = 0;
    total++; if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.mem_valid} !== 4'b0 || bus.rsp_rdata !== 32'd0) begin bad++; $display("FAIL tmo_late v=%b e=%b mv=%b d=%h exp 0", {bus.rsp0_valid, bus.rsp1_valid}, bus.rsp_err, bus.mem_valid, bus.rsp_rdata); end
  endtask

  task automatic test_race;
    idle_inputs();
    bus.req0_valid = 1; bus.req0_addr = 32'h0000_5000;
    cyc();
    bus.req0_valid = 0; bus.mem_ready = 1;
    cyc();
    bus.mem_ready = 0;
    cyc(); cyc(); cyc();
    total++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin bad++; $display("FAIL race_early got=%b exp=00", {bus.rsp0_valid, bus.rsp1_valid}); end
    bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = 32'hA5A5_5A5A;
    cyc();
    bus.mem_rsp_valid = 0;
    total++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b10 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'hA5A5_5A5A) begin bad++; $display("FAIL race_rsp v=%b e=%b d=%h exp v=10 e=0 d=a5a55a5a", {bus.rsp0_valid, bus.rsp1_valid}, bus.rsp_err, bus.rsp_rdata); end
    cyc();
    total++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin bad++; $display("FAIL race_no_err_after got=%b exp=00", {bus.rsp0_valid, bus.rsp1_valid}); end
  endtask

  task automatic test_reset_wait;
    idle_inputs();
    bus.req1_valid = 1; bus.req1_addr = 32'h0000_6000;
    cyc();
    bus.req1_valid = 0; bus.mem_ready = 1;
    cyc();
    bus.mem_ready = 0;
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    total++; if ({bus.mem_valid, bus.rsp0_valid, bus.rsp1_valid, bus.sel} !== 4'b0) begin bad++; $display("FAIL rw_after_rst mv,v0,v1,sel=%b exp 0000", {bus.mem_valid, bus.rsp0_valid, bus.rsp1_valid, bus.sel}); end
    bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = 32'h8888_8888;
    cyc();
    bus.mem_rsp_valid = 0;
    total++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin bad++; $display("FAIL rw_no_rsp got=%b exp=00", {bus.rsp0_valid, bus.rsp1_valid}); end
    bus.req0_valid = 1; bus.req1_valid = 1;
    #1;
    total++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin bad++; $display("FAIL rw_tie got=%b exp=10", {bus.req0_ready, bus.req1_ready}); end
    cyc();
    bus.req0_valid = 0; bus.req1_valid = 0;
    total++; if (bus.sel !== 1'b0 || bus.mem_valid !== 1'b1) begin bad++; $display("FAIL rw_accept sel=%b mv=%b exp sel=0 mv=1", bus.sel, bus.mem_valid); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_race();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
